// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, reserved indices and write-request types for the
// register-file write arbiter and its holding slots.
package rf_write_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PC_REG = 29;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding buffer for a register-file write port.
// Ports: clk/rst; valid/addr/data request in; grant from arbiter;
// ready, full, buf_addr, buf_data out; drop pulses on an illegal accept.
module rf_wr_slot
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = rf_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W = rf_write_arbiter_pkg::ADDR_W,
    parameter int PC_REG = rf_write_arbiter_pkg::PC_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic              drop
);

    logic illegal;
    logic fire;

    assign illegal = (addr == '0) || (addr == ADDR_W'(PC_REG));

    // Granted entry leaves this cycle, so a new request can refill it.
    assign ready = rst || !full || grant;
    assign fire  = valid && ready && !rst;
    assign drop  = fire && illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (fire && !illegal) begin
            full     <= 1'b1;
            buf_addr <= addr;
            buf_data <= data;
        end else if (grant) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter merging writeback (A) and multi-cycle (B) writes
// into one registered register-file write port with read-hazard detect.
// Ports: clk/rst; a_*/b_* valid-ready requests; regwrite/write_register/
// write_data/grant_b registered outputs; rd_addr1/2 -> hazard; drop_cnt.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = rf_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W = rf_write_arbiter_pkg::ADDR_W,
    parameter int PC_REG = rf_write_arbiter_pkg::PC_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              regwrite,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              grant_b,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard,
    output logic [7:0]        drop_cnt
);

    logic              a_full, b_full;
    logic [ADDR_W-1:0] a_buf_addr, b_buf_addr;
    logic [DATA_W-1:0] a_buf_data, b_buf_data;
    logic              a_drop, b_drop;
    logic              a_grant, b_grant;
    grant_e            last_grant;
    logic [8:0]        drop_sum;

    rf_wr_slot #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PC_REG(PC_REG)
    ) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .valid    (a_valid),
        .addr     (a_addr),
        .data     (a_data),
        .grant    (a_grant),
        .ready    (a_ready),
        .full     (a_full),
        .buf_addr (a_buf_addr),
        .buf_data (a_buf_data),
        .drop     (a_drop)
    );

    rf_wr_slot #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PC_REG(PC_REG)
    ) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .valid    (b_valid),
        .addr     (b_addr),
        .data     (b_data),
        .grant    (b_grant),
        .ready    (b_ready),
        .full     (b_full),
        .buf_addr (b_buf_addr),
        .buf_data (b_buf_data),
        .drop     (b_drop)
    );

    // On a tie the port not served last wins.
    assign a_grant = a_full && (!b_full || last_grant == GRANT_B);
    assign b_grant = b_full && (!a_full || last_grant == GRANT_A);

    assign drop_sum = {1'b0, drop_cnt} + 9'(a_drop) + 9'(b_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            grant_b        <= 1'b0;
            last_grant     <= GRANT_B;
            drop_cnt       <= 8'd0;
        end else begin
            if (a_grant) begin
                regwrite       <= 1'b1;
                write_register <= a_buf_addr;
                write_data     <= a_buf_data;
                grant_b        <= 1'b0;
                last_grant     <= GRANT_A;
            end else if (b_grant) begin
                regwrite       <= 1'b1;
                write_register <= b_buf_addr;
                write_data     <= b_buf_data;
                grant_b        <= 1'b1;
                last_grant     <= GRANT_B;
            end else begin
                regwrite       <= 1'b0;
            end
            drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    function automatic logic rd_hit(input logic [ADDR_W-1:0] ra);
        rd_hit = (ra != '0) &&
                 ((a_full && ra == a_buf_addr) ||
                  (b_full && ra == b_buf_addr) ||
                  (regwrite && ra == write_register));
    endfunction

    assign hazard = rd_hit(rd_addr1) || rd_hit(rd_addr2);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios plus random
// traffic checked against a queue-based behavioural model.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic        regwrite, grant_b, hazard;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [4:0]  rd_addr1 = '0, rd_addr2 = '0;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    rf_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .regwrite       (regwrite),
        .write_register (write_register),
        .write_data     (write_data),
        .grant_b        (grant_b),
        .rd_addr1       (rd_addr1),
        .rd_addr2       (rd_addr2),
        .hazard         (hazard),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        b;
    } exp_t;

    ent_t qa[$];
    ent_t qb[$];
    exp_t expq[$];
    bit   last_b = 1'b1;
    bit   out_v  = 1'b0;
    logic [4:0] out_a = '0;
    int   drops = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit pred_ga();
        return qa.size() > 0 && (qb.size() == 0 || last_b);
    endfunction

    function automatic bit pred_gb();
        return qb.size() > 0 && !pred_ga();
    endfunction

    function automatic bit legal(input logic [4:0] ad);
        return ad != 0 && ad != 29;
    endfunction

    function automatic bit pending_hit(input logic [4:0] r);
        bit h;
        h = 1'b0;
        if (r != 0) begin
            foreach (qa[i]) if (qa[i].a == r) h = 1'b1;
            foreach (qb[i]) if (qb[i].a == r) h = 1'b1;
            if (out_v && out_a == r) h = 1'b1;
        end
        return h;
    endfunction

    // Reference model: advances once per clock edge.
    initial begin
        ent_t e;
        bit   ga, gb, ra, rb;
        int   n;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                qa.delete();
                qb.delete();
                expq.delete();
                last_b = 1'b1;
                out_v  = 1'b0;
                out_a  = '0;
                drops  = 0;
            end else begin
                ga = pred_ga();
                gb = pred_gb();
                ra = qa.size() == 0 || ga;
                rb = qb.size() == 0 || gb;
                if (ga) begin
                    e = qa.pop_front();
                    expq.push_back('{e.a, e.d, 1'b0});
                    last_b = 1'b0;
                    out_v = 1'b1;
                    out_a = e.a;
                end else if (gb) begin
                    e = qb.pop_front();
                    expq.push_back('{e.a, e.d, 1'b1});
                    last_b = 1'b1;
                    out_v = 1'b1;
                    out_a = e.a;
                end else begin
                    out_v = 1'b0;
                end
                n = 0;
                if (a_valid && ra) begin
                    if (legal(a_addr)) qa.push_back('{a_addr, a_data});
                    else n++;
                end
                if (b_valid && rb) begin
                    if (legal(b_addr)) qb.push_back('{b_addr, b_data});
                    else n++;
                end
                drops = (drops + n > 255) ? 255 : drops + n;
            end
        end
    end

    // Monitor: samples mid-cycle and compares against the model.
    initial begin
        exp_t x;
        bit   pra, prb;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pra = qa.size() == 0 || pred_ga();
                prb = qb.size() == 0 || pred_gb();
                check("a_ready", 32'(a_ready), 32'(pra));
                check("b_ready", 32'(b_ready), 32'(prb));
                check("hazard", 32'(hazard),
                      32'(pending_hit(rd_addr1) || pending_hit(rd_addr2)));
                check("drop_cnt", 32'(drop_cnt), 32'(drops));
                check("regwrite", 32'(regwrite), 32'(out_v));
                if (regwrite) begin
                    if (expq.size() == 0) begin
                        check("unexpected_write", 32'(regwrite), 32'd0);
                    end else begin
                        x = expq.pop_front();
                        check("write_register", 32'(write_register), 32'(x.a));
                        check("write_data", write_data, x.d);
                        check("grant_b", 32'(grant_b), 32'(x.b));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic set_a(input logic [4:0] ad, input logic [31:0] d);
        a_valid = 1'b1;
        a_addr = ad;
        a_data = d;
    endtask

    task automatic set_b(input logic [4:0] ad, input logic [31:0] d);
        b_valid = 1'b1;
        b_addr = ad;
        b_data = d;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        rd_addr1 = '0;
        rd_addr2 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_wreg", 32'(write_register), 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_grant_b", 32'(grant_b), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        reset_dut();

        // Single port-A write.
        set_a(5'd5, 32'hDEADBEEF);
        step();
        idle();
        step();
        check("single_rw", 32'(regwrite), 32'd1);
        check("single_wreg", 32'(write_register), 32'd5);
        check("single_wdata", write_data, 32'hDEADBEEF);
        check("single_gb", 32'(grant_b), 32'd0);
        step();

        // Simultaneous A and B after reset.
        reset_dut();
        set_a(5'd3, 32'h1111_0003);
        set_b(5'd4, 32'h2222_0004);
        step();
        idle();
        check("tie_b_ready", 32'(b_ready), 32'd0);
        check("tie_a_ready", 32'(a_ready), 32'd1);
        step();
        check("tie_first", 32'(write_register), 32'd3);
        check("tie_first_gb", 32'(grant_b), 32'd0);
        step();
        check("tie_second", 32'(write_register), 32'd4);
        check("tie_second_gb", 32'(grant_b), 32'd1);
        step();
        check("tie_idle", 32'(regwrite), 32'd0);

        // Back-to-back traffic on both ports alternates grants.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            set_a(5'(10 + i), 32'hA000_0000 + 32'(i));
            set_b(5'(20 + i), 32'hB000_0000 + 32'(i));
            step();
            if (i >= 1)
                check("alt_grant", 32'(grant_b), 32'((i % 2) == 0));
        end
        idle();
        repeat (3) step();

        // Illegal writes are dropped and counted, saturating.
        reset_dut();
        set_a(5'd0, 32'h1);
        set_b(5'd29, 32'h2);
        step();
        idle();
        step();
        check("drop_two", 32'(drop_cnt), 32'd2);
        check("drop_no_rw", 32'(regwrite), 32'd0);
        for (int i = 0; i < 150; i++) begin
            set_a(5'd29, 32'(i));
            set_b(5'd0, 32'(i));
            step();
        end
        idle();
        step();
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Hazard on a pending B write.
        reset_dut();
        set_b(5'd7, 32'h7777);
        rd_addr1 = 5'd7;
        step();
        idle();
        check("haz_buf", 32'(hazard), 32'd1);
        step();
        check("haz_out", 32'(hazard), 32'd1);
        rd_addr1 = 5'd0;
        #1;
        check("haz_zero", 32'(hazard), 32'd0);
        rd_addr1 = 5'd7;
        step();
        check("haz_done", 32'(hazard), 32'd0);
        rd_addr1 = 5'd0;

        // Reset with both buffers full discards them immediately.
        reset_dut();
        set_a(5'd12, 32'hC0C0);
        set_b(5'd13, 32'hD0D0);
        step();
        idle();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rw", 32'(regwrite), 32'd0);
        check("mid_rst_wreg", 32'(write_register), 32'd0);
        check("mid_rst_a_ready", 32'(a_ready), 32'd1);
        check("mid_rst_b_ready", 32'(b_ready), 32'd1);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_rw", 32'(regwrite), 32'd0);
        step();
        check("post_rst_rw2", 32'(regwrite), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            a_valid  = 1'($urandom_range(0, 1));
            a_addr   = 5'($urandom_range(0, 31));
            a_data   = $urandom;
            b_valid  = 1'($urandom_range(0, 1));
            b_addr   = 5'($urandom_range(0, 31));
            b_data   = $urandom;
            rd_addr1 = 5'($urandom_range(0, 31));
            rd_addr2 = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        repeat (4) step();
        check("drain_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, write data width; ADDR_W, default 5, register index width; PC_REG, default 29, index reserved for the program counter.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high. Port lists follow as name, direction, width, meaning.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 a_valid, a_addr, a_data  in  1/ADDR_W/DATA_W  write request from pipeline writeback (port A).
REQ-006 a_ready  out  1  port A accept.
REQ-007 b_valid, b_addr, b_data  in  1/ADDR_W/DATA_W  write request from multi-cycle unit (port B).
REQ-008 b_ready  out  1  port B accept.
REQ-009 regwrite, write_register, write_data  out  1/ADDR_W/DATA_W  register-file write port; registered.
REQ-010 grant_b  out  1  registered; 1 means the current output came from port B.
REQ-011 rd_addr1, rd_addr2  in  ADDR_W each  decode-stage read indices.
REQ-012 hazard  out  1  combinational; a pending write targets a read index.
REQ-013 drop_cnt  out  8  count of dropped illegal writes.

Function
REQ-014 Each port SHALL own a one-entry holding buffer (valid, addr, data).
REQ-015 A transfer SHALL occur at a posedge where x_valid=1 and x_ready=1.
REQ-016 x_ready SHALL be 1 when the port's buffer is empty, or when it is granted this cycle (full-throughput pass-through).
REQ-017 A request with addr 0 or addr PC_REG SHALL be accepted but not buffered, and SHALL increment drop_cnt.
REQ-018 drop_cnt SHALL saturate at 255. Two simultaneous drops SHALL add 2, still saturating.
REQ-019 Arbitration SHALL be round-robin over full buffers, using a last_grant flop.
REQ-020 With one buffer full, that buffer SHALL be granted. With both full, the port not granted last SHALL win.
REQ-021 The granted entry SHALL load the output register at the same posedge, setting regwrite=1. The buffer SHALL empty, or refill if a new transfer occurs on that edge.
REQ-022 With no buffer full, regwrite SHALL be 0 at the next edge. write_register and write_data SHALL hold their previous values.
REQ-023 Latency: accepted at edge N, regwrite is visible after edge N+1 at the earliest. The register file commits on the following negedge.
REQ-024 A losing buffer SHALL wait at most one grant cycle.
REQ-025 hazard SHALL be 1 when rd_addr1 or rd_addr2 is nonzero and equals the addr of a full buffer, or equals write_register while regwrite=1.
REQ-026 If both buffers target the same address, port order SHALL be preserved per port only. The team accepts that the last grant defines the final value.

Reset
REQ-027 On rst: both buffers empty; regwrite=0; write_register=0; write_data=0; grant_b=0; last_grant=B (so A wins the first tie); drop_cnt=0.
REQ-028 a_ready and b_ready SHALL be 1 while rst=1 is asserted. Transfers during reset SHALL be ignored.
REQ-029 Reset mid-operation SHALL discard buffered writes without emitting them.

Structure
REQ-030 A shared package SHALL hold DATA_W, ADDR_W, PC_REG, and a write-request struct typedef (valid, addr, data).
REQ-031 The holding buffer SHALL be a sub-module, rf_wr_slot, instantiated twice.

Verification
REQ-032 Single A write: a_valid=1, addr=5, data=0xDEADBEEF for one cycle -> regwrite=1, write_register=5, write_data=0xDEADBEEF two edges later, grant_b=0.
REQ-033 Simultaneous A(addr=3) and B(addr=4) after reset -> A is output first, then B on the next edge. b_ready=0 for one cycle. No loss.
REQ-034 Back-to-back A and B for 8 cycles -> grants alternate A,B,A,B. Neither port waits more than one cycle.
REQ-035 Writes to addr 0 and 29 -> regwrite stays 0 and drop_cnt=2. 300 illegal writes -> drop_cnt=255.
REQ-036 Pending B write to addr 7 with rd_addr1=7 -> hazard=1 until the output cycle ends. rd_addr1=0 -> hazard=0.
REQ-037 Assert rst with both buffers full -> no regwrite pulse. Outputs match REQ-027 immediately, without a clock edge.
